// File: rtl/mdu_stall_ctrl.sv
// Pipeline stall controller for the 5-stage MIPS core: merges load-use, MDU
// occupancy and memory-wait stalls, and sequences the shared iterative MDU.
module mdu_stall_ctrl #(
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_load,
  input  logic [4:0] ex_waddr,
  input  logic       ex_mdu_start,
  input  logic       ex_mdu_op,
  input  logic       mem_stallreq,
  output logic [5:0] stall,
  output logic       mdu_go,
  output logic       mdu_busy,
  output logic       mdu_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  localparam logic [5:0] STALL_LU  = 6'b000111;
  localparam logic [5:0] STALL_MDU = 6'b001111;
  localparam logic [5:0] STALL_MEM = 6'b011111;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mdu_stall;
  logic             go_c;
  logic             done_c;
  logic             lu;
  logic [5:0]       stall_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mdu_stall = 1'b0;
    go_c      = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (ex_mdu_start) begin
          go_c      = 1'b1;
          mdu_stall = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = ex_mdu_op ? DIV_LD : MUL_LD;
        end
      end
      RUN: begin
        // The count keeps running under a memory wait; MEM stalls are independent.
        mdu_stall = 1'b1;
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      DONE: begin
        done_c = 1'b1;
        if (!mem_stallreq) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lu = id_valid & ex_load & (ex_waddr != 5'd0) &
              ((id_use_rs & (id_rs == ex_waddr)) | (id_use_rt & (id_rt == ex_waddr)));

  always_comb begin
    stall_c = 6'b000000;
    if (lu)           stall_c = stall_c | STALL_LU;
    if (mdu_stall)    stall_c = stall_c | STALL_MDU;
    if (mem_stallreq) stall_c = stall_c | STALL_MEM;
  end

  // Outputs are combinational, so they are gated by reset to read zero immediately.
  assign stall    = rst ? stall_c : 6'b000000;
  assign mdu_go   = rst & go_c;
  assign mdu_busy = rst & (state != IDLE);
  assign mdu_done = rst & done_c;

endmodule
